adder_sum_accumulator: RTL and testbench
========================================

// Module: adder_sum_accumulator
// PURPOSE
//  Downstream stage of the registered 32-bit adder: consumes its sum stream and accumulates
//  a programmable block of BLOCK_LEN sums into a wide total. Presents the total on a
//  valid/ready output port with an overflow flag. Back-pressures the producer while a
//  result is held.
// PARAMETERS
//  DATA_W  32  width of each incoming sum
//  ACC_W   40  accumulator width (>= DATA_W); ACC_W-DATA_W guard bits
//  CNT_W   8   width of block length / sample counter
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       asynchronous, active-high reset
//  in_valid   in   1       in_sum valid this cycle
//  in_sum     in   DATA_W  sum from adder stage, unsigned
//  in_ready   out  1       stage accepts in_sum this cycle
//  block_len  in   CNT_W   sums per block; sampled only on first accept of a block
//  out_valid  out  1       out_acc/out_count/overflow valid
//  out_ready  in   1       consumer takes result this cycle
//  out_acc    out  ACC_W   block total
//  out_count  out  CNT_W   number of sums accumulated in this block
//  overflow   out  1       carry out of ACC_W occurred during block (sticky per block)
//  busy       out  1       block in progress (state != IDLE)
// BEHAVIOUR
//  - Reset (async, any time incl. mid-block): state=IDLE, acc=0, cnt=0, len=0; outputs
//    out_valid=0, out_acc=0, out_count=0, overflow=0, busy=0, in_ready=1. Partial block dropped.
//  - Accept = in_valid & in_ready at rising edge. Output transfer = out_valid & out_ready.
//  - FSM IDLE/ACCUM/HOLD:
//    IDLE : in_ready=1. On accept: len<=block_len (0 treated as 1), acc<=zero-ext in_sum,
//           cnt<=1, overflow<=0; -> HOLD if effective len==1, else -> ACCUM.
//    ACCUM: in_ready=1. On accept: acc<=acc+in_sum, cnt<=cnt+1; -> HOLD when cnt+1==len.
//           No accept: hold all state (in_valid gaps allowed, no timeout).
//    HOLD : in_ready=0, out_valid=1; out_* stable until transfer. On transfer -> IDLE,
//           out_valid=0 next cycle. No same-cycle bypass into next block.
//  - Latency: result valid the cycle after the edge that accepts the last sum of a block.
//    Throughput: len+1 cycles/block minimum (one HOLD cycle).
//  - Arithmetic: unsigned, modulo 2^ACC_W; overflow<=1 on any carry out of bit ACC_W-1.
//  - out_acc/out_count are driven from acc/cnt registers (no combinational path from inputs).
//  - block_len changes mid-block are ignored; new value takes effect on next block.
//  - out_ready high while out_valid=0 has no effect.
// CONFIGURATION
//  ADDER_SUM_ACC_SAT_EN defined: on carry out, acc clamps to all-ones (2^ACC_W-1) and stays
//    clamped for rest of block; overflow still set.
//  Undefined: acc wraps modulo 2^ACC_W; overflow set as above.
// STRUCTURE
//  Shared package adder_pkg: DATA_W default constant, acc_state_t enum {IDLE,ACCUM,HOLD}.
//  One sub-module: acc_sat_add (ACC_W adder, carry out, saturation under the macro).
//  FSM, counter and output registers live in this module.
// TESTING
//  1 block_len=4, sums 1,2,3,4 back-to-back, out_ready=1 -> out_acc=10, out_count=4,
//    overflow=0, out_valid one cycle after 4th accept, in_ready=0 that cycle.
//  2 block_len=0, sum 0x0000_0005 -> treated as len 1: out_acc=5, out_count=1.
//  3 ACC_W=32 build, len=2, sums 0xFFFF_FFFF,0x2 -> wrap: out_acc=1, overflow=1;
//    with ADDER_SUM_ACC_SAT_EN: out_acc=0xFFFF_FFFF, overflow=1.
//  4 len=3, out_ready=0 for 5 cycles in HOLD, in_valid=1 -> in_ready=0, out_* stable,
//    no sum consumed; after transfer next block starts from fresh acc.
//  5 len=4, 2 sums accepted then reset pulse (async, mid-cycle) -> all outputs 0 immediately;
//    following block of 4 sums of 7 -> out_acc=28.
//  6 len=3 with in_valid gaps (1,0,0,1,0,1), change block_len to 9 mid-block ->
//    out_count=3; next block uses 9.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and defaults for the adder pipeline stages.
package adder_pkg;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_t;
endpackage

// File: rtl/acc_sat_add.sv
// ACC_W-bit unsigned adder with carry out; clamps to all-ones on carry when
// ADDER_SUM_ACC_SAT_EN is defined, otherwise wraps modulo 2^ACC_W.
module acc_sat_add #(
  parameter int ACC_W = 40
) (
  input  logic [ACC_W-1:0] i_a,
  input  logic [ACC_W-1:0] i_b,
  output logic [ACC_W-1:0] o_sum,
  output logic             o_carry
);
  logic [ACC_W:0] w_full;

  assign w_full  = {1'b0, i_a} + {1'b0, i_b};
  assign o_carry = w_full[ACC_W];

`ifdef ADDER_SUM_ACC_SAT_EN
  // A clamped total stays clamped: any non-zero addend carries again.
  assign o_sum = o_carry ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];
`else
  assign o_sum = w_full[ACC_W-1:0];
`endif
endmodule

// File: rtl/adder_sum_accumulator.sv
// Accumulates a block of block_len sums into a wide total held on a valid/ready port.
// Saturating vs wrapping arithmetic selected by ADDER_SUM_ACC_SAT_EN (see acc_sat_add).
module adder_sum_accumulator
  import adder_pkg::*;
#(
  parameter int DATA_W = adder_pkg::DATA_W,
  parameter int ACC_W  = 40,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_sum,
  output logic              in_ready,
  input  logic [CNT_W-1:0]  block_len,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_count,
  output logic              overflow,
  output logic              busy
);
  acc_state_t       r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_len;
  logic             r_ovf;

  logic [ACC_W-1:0] w_sum_ext;
  logic [ACC_W-1:0] w_add_sum;
  logic             w_add_carry;
  logic [CNT_W-1:0] w_len_eff;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_accept;

  assign w_sum_ext = ACC_W'(in_sum);
  assign w_len_eff = (block_len == '0) ? CNT_W'(1) : block_len;
  assign w_cnt_nxt = r_cnt + CNT_W'(1);
  assign w_accept  = in_valid && in_ready;

  acc_sat_add #(.ACC_W(ACC_W)) u_add (
    .i_a     (r_acc),
    .i_b     (w_sum_ext),
    .o_sum   (w_add_sum),
    .o_carry (w_add_carry)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_len   <= w_len_eff;
            r_acc   <= w_sum_ext;
            r_cnt   <= CNT_W'(1);
            r_ovf   <= 1'b0;
            r_state <= (w_len_eff == CNT_W'(1)) ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (w_accept) begin
            r_acc <= w_add_sum;
            r_cnt <= w_cnt_nxt;
            r_ovf <= r_ovf | w_add_carry;
            if (w_cnt_nxt == r_len) r_state <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Everything below is decoded from registers only; no input-to-output paths.
  assign in_ready  = (r_state != HOLD);
  assign out_valid = (r_state == HOLD);
  assign busy      = (r_state != IDLE);
  assign out_acc   = r_acc;
  assign out_count = r_cnt;
  assign overflow  = r_ovf;
endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Directed-vector bench for adder_sum_accumulator (40-bit default and a 32-bit build).
module tb_adder_sum_accumulator;
  logic        clk = 1'b0;
  logic        reset;

  logic        in_valid, in_ready, out_valid, out_ready, overflow, busy;
  logic [31:0] in_sum;
  logic [7:0]  block_len, out_count;
  logic [39:0] out_acc;

  logic        n_valid, n_ready, n_out_valid, n_out_ready, n_overflow, n_busy;
  logic [31:0] n_sum, n_acc;
  logic [7:0]  n_len, n_count;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  adder_sum_accumulator #(.DATA_W(32), .ACC_W(40), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sum(in_sum), .in_ready(in_ready),
    .block_len(block_len), .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .out_count(out_count), .overflow(overflow), .busy(busy)
  );

  adder_sum_accumulator #(.DATA_W(32), .ACC_W(32), .CNT_W(8)) dut32 (
    .clk(clk), .reset(reset), .in_valid(n_valid), .in_sum(n_sum), .in_ready(n_ready),
    .block_len(n_len), .out_valid(n_out_valid), .out_ready(n_out_ready), .out_acc(n_acc),
    .out_count(n_count), .overflow(n_overflow), .busy(n_busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one sum and wait (bounded) for it to be accepted.
  task automatic send(input logic [31:0] s);
    logic rdy;
    logic done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_sum   = s;
    for (int k = 0; k < 20 && !done; k++) begin
      rdy = in_ready;
      tick();
      done = rdy;
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_sum = '0; block_len = 8'd0; out_ready = 1'b1;
    n_valid = 1'b0; n_sum = '0; n_len = 8'd0; n_out_ready = 1'b1;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_acc", out_acc, 0);
    chk("rst_cnt", out_count, 0);
    chk("rst_ovf", overflow, 0);
    #14 reset = 1'b0;
    tick();

    // 1: len 4, back-to-back sums 1..4
    block_len = 8'd4;
    send(32'd1); send(32'd2); send(32'd3);
    chk("t1_not_yet_valid", out_valid, 0);
    chk("t1_busy", busy, 1);
    send(32'd4);
    chk("t1_valid", out_valid, 1);
    chk("t1_in_ready_low", in_ready, 0);
    chk("t1_acc", out_acc, 10);
    chk("t1_cnt", out_count, 4);
    chk("t1_ovf", overflow, 0);
    tick();
    chk("t1_valid_drop", out_valid, 0);
    chk("t1_idle", busy, 0);

    // 2: len 0 behaves as len 1
    block_len = 8'd0;
    send(32'h0000_0005);
    chk("t2_valid", out_valid, 1);
    chk("t2_acc", out_acc, 5);
    chk("t2_cnt", out_count, 1);
    tick();

    // 4: held result under back-pressure, producer still offering
    block_len = 8'd3; out_ready = 1'b0;
    send(32'd10); send(32'd20); send(32'd30);
    in_valid = 1'b1; in_sum = 32'd99;
    for (int k = 0; k < 5; k++) tick();
    chk("t4_in_ready", in_ready, 0);
    chk("t4_valid", out_valid, 1);
    chk("t4_acc_stable", out_acc, 60);
    chk("t4_cnt_stable", out_count, 3);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("t4_released", out_valid, 0);
    send(32'd1); send(32'd1); send(32'd1);
    chk("t4_fresh_acc", out_acc, 3);
    chk("t4_fresh_cnt", out_count, 3);
    tick();

    // 5: async reset mid-block
    block_len = 8'd4;
    send(32'd7); send(32'd7);
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_acc", out_acc, 0);
    chk("t5_rst_cnt", out_count, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_in_ready", in_ready, 1);
    chk("t5_rst_valid", out_valid, 0);
    #3 reset = 1'b0;
    tick();
    send(32'd7); send(32'd7); send(32'd7); send(32'd7);
    chk("t5_acc", out_acc, 28);
    chk("t5_cnt", out_count, 4);
    tick();

    // 6: in_valid gaps 1,0,0,1,0,1 and block_len change mid-block
    block_len = 8'd3;
    send(32'd5);
    block_len = 8'd9;
    tick(); tick();
    send(32'd6);
    tick();
    send(32'd7);
    chk("t6_valid", out_valid, 1);
    chk("t6_cnt", out_count, 3);
    chk("t6_acc", out_acc, 18);
    tick();
    for (int k = 0; k < 8; k++) send(32'd1);
    chk("t6_len9_not_done", out_valid, 0);
    send(32'd1);
    chk("t6_len9_valid", out_valid, 1);
    chk("t6_len9_cnt", out_count, 9);
    chk("t6_len9_acc", out_acc, 9);
    tick();

    // 3: carry out of the accumulator; 40-bit build absorbs it in guard bits
    block_len = 8'd2; n_len = 8'd3;
    n_valid = 1'b1; n_sum = 32'hFFFF_FFFF;
    in_valid = 1'b1; in_sum = 32'hFFFF_FFFF;
    tick();
    n_sum = 32'h2; in_sum = 32'h2;
    tick();
    in_valid = 1'b0;
    chk("t3_wide_acc", out_acc, 40'h01_0000_0001);
    chk("t3_wide_ovf", overflow, 0);
    n_sum = 32'h5;
    tick();
    n_valid = 1'b0;
    chk("t3_n_valid", n_out_valid, 1);
    chk("t3_n_ovf", n_overflow, 1);
`ifdef ADDER_SUM_ACC_SAT_EN
    chk("t3_n_acc_sat", n_acc, 32'hFFFF_FFFF);
`else
    chk("t3_n_acc_wrap", n_acc, 32'h6);
`endif
    tick();
    chk("t3_n_release", n_out_valid, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
